folded_threshold_eval: RTL and testbench

- Sequential, parametrised successor to the combinational 7-input majority (Maj7) block.
- Evaluates `popcount(vec) >= T` on an N-bit vector over ceil(N/LANES) cycles, folding LANES bits per cycle into one shared accumulator.
- Threshold T is either strict majority or a per-transaction programmable value.
- Sits behind a valid/ready producer and feeds a valid/ready consumer; used to trade area for latency in wide majority/threshold evaluation.

---
 rtl/folded_threshold_eval.sv | 128 ++++++++++++
 tb/tb_folded_threshold_eval.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/folded_threshold_eval.sv
// folded_threshold_eval
// Computes popcount(vec) >= threshold over ceil(N/LANES) cycles. Each cycle
// folds LANES bits of the captured vector into one shared accumulator, so
// wide threshold evaluation costs latency instead of adder area.
//
// state  | meaning
// IDLE   | ready for a new vector; in_ready high
// ACCUM  | folding one LANES-wide slice per cycle into the accumulator
// DONE   | result presented and held until the consumer takes it

module folded_threshold_eval #(
  parameter int N     = 7,
  parameter int LANES = 1,
  parameter int CW    = $clog2(N + 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_vec,
  input  logic          in_thr_sel,
  input  logic [CW-1:0] in_thr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_y,
  output logic [CW-1:0] out_count,
  output logic          busy
);

  // idx never exceeds N+LANES-1, so this width holds idx + LANES safely
  localparam int IW = $clog2(N + LANES + 1);
  // strict majority: an exact half (even N) is not enough
  localparam logic [CW-1:0] MAJ_THR = CW'(N / 2 + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [N-1:0]        vec_q;
  logic [CW-1:0]       thr_q;
  logic [CW-1:0]       acc_q;
  logic [CW-1:0]       acc_d;
  logic [IW-1:0]       idx_q;
  logic [IW-1:0]       idx_d;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                out_y_q;
  logic [CW-1:0]       out_count_q;
  logic                busy_q;

  logic [N+LANES-1:0]  vec_pad;
  logic [LANES-1:0]    slice;
  logic                last_slice;

  // Slice extraction and accumulate; zero padding above bit N-1 masks the tail slice
  always_comb begin
    vec_pad    = {{LANES{1'b0}}, vec_q};
    slice      = LANES'(vec_pad >> idx_q);
    acc_d      = acc_q + CW'($countones(slice));
    idx_d      = idx_q + IW'(LANES);
    last_slice = (idx_d >= IW'(N));
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      thr_q       <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_y_q     <= 1'b0;
      out_count_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            vec_q      <= in_vec;
            thr_q      <= in_thr_sel ? in_thr : MAJ_THR;
            acc_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          acc_q <= acc_d;
          idx_q <= idx_d;
          if (last_slice) begin
            out_valid_q <= 1'b1;
            out_count_q <= acc_d;
            out_y_q     <= (acc_d >= thr_q);
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          // in_ready stays low here, so a new accept waits one cycle after the handshake
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_count = out_count_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_folded_threshold_eval.sv
// Directed bench for folded_threshold_eval: three instances cover
// N=7/LANES=1, N=7/LANES=3 and N=8/LANES=4.

module tb_folded_threshold_eval;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A: N=7, LANES=1
  logic       a_in_valid, a_in_ready, a_in_thr_sel, a_out_valid, a_out_ready, a_out_y, a_busy;
  logic [6:0] a_in_vec;
  logic [3:0] a_in_thr, a_out_count;
  // instance B: N=7, LANES=3
  logic       b_in_valid, b_in_ready, b_in_thr_sel, b_out_valid, b_out_ready, b_out_y, b_busy;
  logic [6:0] b_in_vec;
  logic [3:0] b_in_thr, b_out_count;
  // instance C: N=8, LANES=4
  logic       c_in_valid, c_in_ready, c_in_thr_sel, c_out_valid, c_out_ready, c_out_y, c_busy;
  logic [7:0] c_in_vec;
  logic [3:0] c_in_thr, c_out_count;

  folded_threshold_eval #(.N(7), .LANES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_vec(a_in_vec), .in_thr_sel(a_in_thr_sel), .in_thr(a_in_thr),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_y(a_out_y),
    .out_count(a_out_count), .busy(a_busy));

  folded_threshold_eval #(.N(7), .LANES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_vec(b_in_vec), .in_thr_sel(b_in_thr_sel), .in_thr(b_in_thr),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_y(b_out_y),
    .out_count(b_out_count), .busy(b_busy));

  folded_threshold_eval #(.N(8), .LANES(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_vec(c_in_vec), .in_thr_sel(c_in_thr_sel), .in_thr(c_in_thr),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_y(c_out_y),
    .out_count(c_out_count), .busy(c_busy));

  function automatic logic get_ready(int w);
    case (w)
      0: return a_in_ready;
      1: return b_in_ready;
      default: return c_in_ready;
    endcase
  endfunction

  function automatic logic get_valid(int w);
    case (w)
      0: return a_out_valid;
      1: return b_out_valid;
      default: return c_out_valid;
    endcase
  endfunction

  function automatic logic get_y(int w);
    case (w)
      0: return a_out_y;
      1: return b_out_y;
      default: return c_out_y;
    endcase
  endfunction

  function automatic logic [3:0] get_count(int w);
    case (w)
      0: return a_out_count;
      1: return b_out_count;
      default: return c_out_count;
    endcase
  endfunction

  function automatic logic get_busy(int w);
    case (w)
      0: return a_busy;
      1: return b_busy;
      default: return c_busy;
    endcase
  endfunction

  function automatic logic get_oready(int w);
    case (w)
      0: return a_out_ready;
      1: return b_out_ready;
      default: return c_out_ready;
    endcase
  endfunction

  function automatic int pop7(logic [6:0] v);
    int p;
    p = 0;
    for (int i = 0; i < 7; i++) p += int'(v[i]);
    return p;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge
  task automatic accept(int w, logic [7:0] vec, logic sel, logic [3:0] thr, output int acc_cyc);
    int n;
    n = 0;
    case (w)
      0: begin a_in_valid = 1'b1; a_in_vec = vec[6:0]; a_in_thr_sel = sel; a_in_thr = thr; end
      1: begin b_in_valid = 1'b1; b_in_vec = vec[6:0]; b_in_thr_sel = sel; b_in_thr = thr; end
      default: begin c_in_valid = 1'b1; c_in_vec = vec; c_in_thr_sel = sel; c_in_thr = thr; end
    endcase
    while (!get_ready(w) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(get_ready(w)), 32'd1);
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    case (w)
      0: a_in_valid = 1'b0;
      1: b_in_valid = 1'b0;
      default: c_in_valid = 1'b0;
    endcase
    chk("accum_busy", 32'(get_busy(w)), 32'd1);
    chk("accum_in_ready", 32'(get_ready(w)), 32'd0);
  endtask

  task automatic result(int w, int exp_lat, int exp_cnt, logic exp_y, string tag);
    int n;
    n = 0;
    while (!get_valid(w) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_count"}, 32'(get_count(w)), 32'(exp_cnt));
    chk({tag, "_y"}, 32'(get_y(w)), 32'(exp_y));
    chk({tag, "_done_in_ready"}, 32'(get_ready(w)), 32'd0);
    if (get_oready(w)) begin
      @(negedge clk);
      chk({tag, "_valid_drop"}, 32'(get_valid(w)), 32'd0);
      chk({tag, "_idle_in_ready"}, 32'(get_ready(w)), 32'd1);
    end
  endtask

  initial begin
    int ac, prev, p, seen;
    a_in_valid = 0; a_in_vec = '0; a_in_thr_sel = 0; a_in_thr = '0; a_out_ready = 1;
    b_in_valid = 0; b_in_vec = '0; b_in_thr_sel = 0; b_in_thr = '0; b_out_ready = 1;
    c_in_valid = 0; c_in_vec = '0; c_in_thr_sel = 0; c_in_thr = '0; c_out_ready = 1;
    prev = 0;

    // reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      chk("rst_in_ready", 32'(get_ready(w)), 32'd1);
      chk("rst_out_valid", 32'(get_valid(w)), 32'd0);
      chk("rst_out_y", 32'(get_y(w)), 32'd0);
      chk("rst_out_count", 32'(get_count(w)), 32'd0);
      chk("rst_busy", 32'(get_busy(w)), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // full majority sweep, N=7 LANES=1: latency 7, period 9
    for (int v = 0; v < 128; v++) begin
      accept(0, 8'(v), 1'b0, 4'd0, ac);
      if (v > 0) chk("maj7_period", 32'(ac - prev), 32'd9);
      prev = ac;
      p = pop7(7'(v));
      result(0, 7, p, (p >= 4), "maj7");
    end

    // LANES=3: tail slice covers bits 6..8, bits 7 and 8 must read as zero
    accept(1, 8'b0101_1010, 1'b0, 4'd0, ac);
    result(1, 3, 4, 1'b1, "lanes3_a");
    accept(1, 8'b0100_0110, 1'b0, 4'd0, ac);
    result(1, 3, 3, 1'b0, "lanes3_b");

    // programmable threshold boundaries
    accept(0, 8'h00, 1'b1, 4'd0, ac);
    result(0, 7, 0, 1'b1, "thr0");
    accept(0, 8'h7F, 1'b1, 4'd7, ac);
    result(0, 7, 7, 1'b1, "thr7");
    accept(0, 8'h7F, 1'b1, 4'd8, ac);
    result(0, 7, 7, 1'b0, "thr8");
    accept(0, 8'h7F, 1'b1, 4'd15, ac);
    result(0, 7, 7, 1'b0, "thr15");

    // backpressure: outputs frozen, concurrent request ignored
    a_out_ready = 1'b0;
    accept(0, 8'h55, 1'b0, 4'd0, ac);
    result(0, 7, 4, 1'b1, "bp");
    a_in_valid = 1'b1; a_in_vec = 7'h03; a_in_thr_sel = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(a_out_valid), 32'd1);
      chk("bp_hold_count", 32'(a_out_count), 32'd4);
      chk("bp_hold_y", 32'(a_out_y), 32'd1);
      chk("bp_hold_in_ready", 32'(a_in_ready), 32'd0);
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(a_out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(a_in_ready), 32'd1);
    accept(0, 8'h03, 1'b0, 4'd0, ac);
    result(0, 7, 2, 1'b0, "bp_pending");

    // reset in the third ACCUM cycle aborts the transaction
    accept(0, 8'h7F, 1'b0, 4'd0, ac);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_in_ready", 32'(a_in_ready), 32'd1);
    chk("abort_out_valid", 32'(a_out_valid), 32'd0);
    chk("abort_busy", 32'(a_busy), 32'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (a_out_valid) seen = 1;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    accept(0, 8'h0F, 1'b0, 4'd0, ac);
    result(0, 7, 4, 1'b1, "after_abort");

    // N=8 strict majority (threshold 5), latency 2
    accept(2, 8'hF0, 1'b0, 4'd0, ac);
    result(2, 2, 4, 1'b0, "n8_tie");
    accept(2, 8'hF8, 1'b0, 4'd0, ac);
    result(2, 2, 5, 1'b1, "n8_maj");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
